// File: rtl/tcb_lib_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate between PN managers.
// Grants hold through backpressure and lock; responses are routed back after DLY cycles.
module tcb_lib_arbiter #(
    parameter int PN  = 2,
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8,
    parameter int DLY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PN-1:0]              man_vld,
    input  logic [PN-1:0]              man_lck,
    input  logic [PN-1:0]              man_wen,
    input  logic [PN*ABW-1:0]          man_adr,
    input  logic [PN*(DBW/SLW)-1:0]    man_ben,
    input  logic [PN*DBW-1:0]          man_wdt,
    output logic [PN-1:0]              man_rdy,
    output logic [PN-1:0]              man_rsp,
    output logic [DBW-1:0]             man_rdt,
    output logic                       man_err,
    output logic                       sub_vld,
    output logic                       sub_lck,
    output logic                       sub_wen,
    output logic [ABW-1:0]             sub_adr,
    output logic [DBW/SLW-1:0]         sub_ben,
    output logic [DBW-1:0]             sub_wdt,
    input  logic                       sub_rdy,
    input  logic [DBW-1:0]             sub_rdt,
    input  logic                       sub_err
);

    localparam int BEW = DBW / SLW;
    localparam int PW  = (PN > 1) ? $clog2(PN) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] gnt_q, gnt_nxt;
    logic [PW-1:0] sel, g, ptr_inc;
    logic          xfer;

    // Lowest requester overall covers the wrap case; lowest at or after ptr overrides it.
    always_comb begin
        sel = ptr;
        for (int i = PN - 1; i >= 0; i--) begin
            if (man_vld[i]) sel = PW'(i);
        end
        for (int i = PN - 1; i >= 0; i--) begin
            if (man_vld[i] && (PW'(i) >= ptr)) sel = PW'(i);
        end
    end

    assign g       = (state == IDLE) ? sel : gnt_q;
    assign ptr_inc = (g == PW'(PN - 1)) ? '0 : g + 1'b1;

    always_comb begin
        sub_vld = 1'b0;
        sub_lck = man_lck[0];
        sub_wen = man_wen[0];
        sub_adr = man_adr[0 +: ABW];
        sub_ben = man_ben[0 +: BEW];
        sub_wdt = man_wdt[0 +: DBW];
        man_rdy = '0;
        for (int i = 0; i < PN; i++) begin
            if (g == PW'(i)) begin
                sub_vld    = man_vld[i] & ~rst;
                sub_lck    = man_lck[i];
                sub_wen    = man_wen[i];
                sub_adr    = man_adr[i*ABW +: ABW];
                sub_ben    = man_ben[i*BEW +: BEW];
                sub_wdt    = man_wdt[i*DBW +: DBW];
                man_rdy[i] = sub_rdy & ~rst;
            end
        end
    end

    assign xfer    = sub_vld & sub_rdy;
    assign man_rdt = sub_rdt;
    assign man_err = sub_err;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_q;
        case (state)
            IDLE: begin
                gnt_nxt = g;
                if (sub_vld && !sub_rdy) begin
                    state_nxt = HOLD;
                end else if (xfer && sub_lck) begin
                    state_nxt = LOCK;
                end else if (xfer) begin
                    ptr_nxt = ptr_inc;
                end
            end
            HOLD: begin
                if (xfer) begin
                    if (sub_lck) begin
                        state_nxt = LOCK;
                    end else begin
                        state_nxt = IDLE;
                        ptr_nxt   = ptr_inc;
                    end
                end else if (!sub_vld) begin
                    // Manager withdrew its request: release without advancing priority.
                    state_nxt = IDLE;
                end
            end
            LOCK: begin
                if (xfer && !sub_lck) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ptr_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt_q <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt_q <= gnt_nxt;
        end
    end

    generate
        if (DLY == 0) begin : g_nodly
            always_comb begin
                man_rsp = '0;
                for (int i = 0; i < PN; i++) begin
                    if (xfer && (g == PW'(i))) man_rsp[i] = 1'b1;
                end
            end
        end else begin : g_pipe
            logic [DLY-1:0] pv;
            logic [PW-1:0]  pi [DLY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv <= '0;
                    for (int k = 0; k < DLY; k++) pi[k] <= '0;
                end else begin
                    pv[0] <= xfer;
                    pi[0] <= g;
                    for (int k = 1; k < DLY; k++) begin
                        pv[k] <= pv[k-1];
                        pi[k] <= pi[k-1];
                    end
                end
            end

            always_comb begin
                man_rsp = '0;
                for (int i = 0; i < PN; i++) begin
                    if (pv[DLY-1] && (pi[DLY-1] == PW'(i))) man_rsp[i] = 1'b1;
                end
            end
        end
    endgenerate

endmodule
